// File: rtl/fetch_pkg.sv
// Shared fetch-control definitions: FSM states, opcode encodings and the jump-offset table.
// Pure constants and types; no latency, no backpressure.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;
  localparam logic [3:0] JMP_OP     = 4'b1111;
  localparam logic [3:0] BRZ_OP     = 4'b1110;

  // Signed 8-bit entries, index 15 leftmost; sign-extended to PC width by jump_lut.
  // idx: 0:0 1:-2 2:+5 3:+3 4:-1 5:+7 6:-8 7:+12 8:0 9:+1 10:-4 11:+16 12:-16 13:+2 14:-3 15:+100
  localparam logic [15:0][7:0] OFFSET_TABLE = {
    8'h64, 8'hFD, 8'h02, 8'hF0, 8'h10, 8'hFC, 8'h01, 8'h00,
    8'h0C, 8'hF8, 8'h07, 8'hFF, 8'h03, 8'h05, 8'hFE, 8'h00
  };

endpackage

// File: rtl/jump_lut.sv
// Index-to-offset lookup, sign-extended to D bits so PC addition wraps modulo 2^D.
// Purely combinational (zero latency); no backpressure.
module jump_lut
  import fetch_pkg::*;
#(
  parameter int D = 12
) (
  input  logic [3:0]   idx,
  output logic [D-1:0] offset
);

  assign offset = D'($signed(OFFSET_TABLE[idx]));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: launch strobe, same-cycle relative-jump decode, halt detection, retire count.
// Decode outputs are combinational (zero latency), done is registered; no backpressure.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_req,
  input  logic [D-1:0] prog_ctr,
  input  logic [W-1:0] instr_in,
  input  logic         flag_z,
  output logic         start,
  output logic         done,
  output logic         reljump_en,
  output logic [D-1:0] offset,
  output logic [W-1:0] instr_out,
  output logic         instr_valid,
  output logic [15:0]  instr_count
);

  state_t       state;
  state_t       state_nxt;
  logic         is_halt;
  logic [3:0]   opcode;
  logic         jump_hit;
  logic [D-1:0] lut_ofs;

  jump_lut #(.D(D)) u_lut (
    .idx    (instr_in[3:0]),
    .offset (lut_ofs)
  );

  assign is_halt     = (instr_in == W'(HALT_INSTR));
  assign opcode      = instr_in[8:5];
  assign instr_valid = (state == LAUNCH) || (state == RUN);
  assign instr_out   = instr_valid ? instr_in : '0;
  assign start       = (state == LAUNCH);
  assign done        = (state == DONE);

  // A zero table entry is a no-op jump, so it never raises reljump_en.
  assign jump_hit   = instr_valid && !is_halt &&
                      ((opcode == JMP_OP) || ((opcode == BRZ_OP) && flag_z));
  assign reljump_en = jump_hit && (lut_ofs != '0);
  assign offset     = reljump_en ? lut_ofs : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = RUN;
      RUN:     if (is_halt) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // prog_ctr is owned by the PC unit; it is not needed for sequencing here.
  logic unused_pc;
  assign unused_pc = ^prog_ctr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (instr_valid && (instr_count != 16'hFFFF))
        instr_count <= instr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a bench-side ROM and PC unit run directed programs.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        start_req;
  logic [11:0] prog_ctr;
  logic [8:0]  instr_in;
  logic        flag_z;
  logic        start;
  logic        done;
  logic        reljump_en;
  logic [11:0] offset;
  logic [8:0]  instr_out;
  logic        instr_valid;
  logic [15:0] instr_count;

  fetch_ctrl #(.D(12), .W(9)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_req   (start_req),
    .prog_ctr    (prog_ctr),
    .instr_in    (instr_in),
    .flag_z      (flag_z),
    .start       (start),
    .done        (done),
    .reljump_en  (reljump_en),
    .offset      (offset),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction ROM and external PC unit.
  logic [8:0] rom [0:63];
  assign instr_in = rom[prog_ctr[5:0]];

  always @(posedge clk or negedge reset) begin
    if (!reset)
      prog_ctr <= 12'd0;
    else if (instr_valid)
      prog_ctr <= reljump_en ? prog_ctr + offset : prog_ctr + 12'd1;
  end

  typedef struct packed {
    logic [11:0] pc;
    logic [8:0]  ins;
    logic        rj;
    logic [11:0] off;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   strict   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input int pc, input logic [8:0] ins, input logic rj, input logic [11:0] off);
    exp_t e;
    e.pc  = 12'(pc);
    e.ins = ins;
    e.rj  = rj;
    e.off = off;
    exp_q.push_back(e);
  endtask

  task automatic push_nops(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) push(p, 9'h000, 1'b0, 12'h000);
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 64; a++) rom[a] = 9'h000;
  endtask

  // Reset pulse released between edges with start_req already high.
  task automatic launch();
    @(negedge clk);
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    start_req = 1'b1;
    @(posedge clk);
    #1 start_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk("done_reached", done, 1'b1);
  endtask

  // Monitor: every retired instruction is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset && instr_valid) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("retire", {prog_ctr, instr_out, reljump_en, offset}, e);
      end else if (strict) begin
        chk("unexpected_retire", instr_valid, 1'b0);
      end
    end
  end

  initial begin
    reset     = 1'b0;
    start_req = 1'b0;
    flag_z    = 1'b0;
    clear_rom();
    rom[0] = 9'h1E2;

    // Reset and IDLE: a live jump word at the ROM output must not leak through.
    repeat (2) @(negedge clk);
    chk("reset_outputs", {start, done, instr_valid, reljump_en, offset, instr_out, instr_count}, 41'd0);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", {start, done, instr_valid, reljump_en, offset, instr_out, instr_count}, 41'd0);

    // Program A: JMP idx2 at 3 -> 8, BRZ idx1 at 10 with flag_z=0, JMP idx0 (zero entry) at 12, HALT at 20.
    rom[0]  = 9'h000;
    rom[3]  = 9'h1E2;
    rom[10] = 9'h1C1;
    rom[12] = 9'h1E0;
    rom[20] = 9'h1FF;
    strict  = 1'b1;
    push_nops(0, 2);
    push(3, 9'h1E2, 1'b1, 12'd5);
    push_nops(8, 9);
    push(10, 9'h1C1, 1'b0, 12'd0);
    push(11, 9'h000, 1'b0, 12'd0);
    push(12, 9'h1E0, 1'b0, 12'd0);
    push_nops(13, 19);
    push(20, 9'h1FF, 1'b0, 12'd0);
    launch();
    @(negedge clk);
    chk("start_first_cycle", {start, instr_valid}, 2'b11);
    @(negedge clk);
    chk("start_one_cycle", {start, instr_valid}, 2'b01);
    wait_done(100);
    chk("count_prog_a", instr_count, 16'd17);
    chk("queue_drained_a", exp_q.size(), 0);

    // Program C: straight line, HALT at 20; later start_req must be ignored.
    #1 clear_rom();
    rom[20] = 9'h1FF;
    push_nops(0, 19);
    push(20, 9'h1FF, 1'b0, 12'd0);
    launch();
    for (int i = 0; i < 100 && !(instr_valid && instr_out == 9'h1FF); i++) @(negedge clk);
    chk("halt_seen", instr_out, 9'h1FF);
    chk("done_not_early", done, 1'b0);
    @(negedge clk);
    chk("done_after_halt", {done, prog_ctr, instr_count}, {1'b1, 12'd21, 16'd21});
    @(negedge clk);
    chk("pc_held", prog_ctr, 12'd21);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    @(negedge clk);
    chk("restart_ignored", {start, done, prog_ctr, instr_count}, {1'b0, 1'b1, 12'd21, 16'd21});
    chk("queue_drained_c", exp_q.size(), 0);

    // Program B: BRZ idx1 at 10 with flag_z=1 loops 8..10 until the counter saturates.
    strict = 1'b0;
    #1 clear_rom();
    rom[10] = 9'h1C1;
    flag_z  = 1'b1;
    push_nops(0, 9);
    push(10, 9'h1C1, 1'b1, 12'hFFE);
    push_nops(8, 9);
    push(10, 9'h1C1, 1'b1, 12'hFFE);
    launch();
    repeat (70000) @(negedge clk);
    chk("count_saturated", instr_count, 16'hFFFF);
    chk("queue_drained_b", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    chk("count_no_wrap", {instr_valid, instr_count}, {1'b1, 16'hFFFF});

    // Asynchronous abort mid-RUN, sampled before any further clock edge.
    #2 reset = 1'b0;
    #1;
    chk("async_reset_midrun", {start, done, instr_valid, reljump_en, offset, instr_out, instr_count}, 41'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_abort", {start, done, instr_valid, instr_count}, 19'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
